pc_unit: RTL and testbench

Parametrised program-counter unit for the RV32I pipeline fetch stage. It generates the fetch PC each cycle and supports stall, prioritised redirects (trap, mret, EX branch, ID jump) and misaligned-target fault detection. It holds the exception PC (epc) and implements a boot/run/halt state machine. It drives the IF-stage instruction memory address and the IF/ID pipeline register.

---
 rtl/pc_unit.sv | 109 ++++++++++
 tb/tb_pc_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: RV32I fetch-stage program counter with prioritised redirects, epc and boot/run/halt control.
// Latency: redirect/trap visible on pc_out one cycle later; backpressure: stall holds pc_out, redirects override it.
module pc_unit #(
    parameter int unsigned        A_WIDTH      = 32,
    parameter logic [A_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [A_WIDTH-1:0] TRAP_VECTOR  = A_WIDTH'(32'h0000_0100)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               trap_req,
    input  logic [A_WIDTH-1:0] trap_epc,
    input  logic               mret,
    input  logic               ex_branch_taken,
    input  logic [A_WIDTH-1:0] ex_branch_target,
    input  logic               id_jump,
    input  logic [A_WIDTH-1:0] id_jump_target,
    input  logic               halt_req,
    input  logic               resume,
    output logic [A_WIDTH-1:0] pc_out,
    output logic [A_WIDTH-1:0] pc_plus4,
    output logic               fetch_valid,
    output logic [A_WIDTH-1:0] epc,
    output logic               misalign_fault,
    output logic               halted
);

    localparam logic [1:0] ST_BOOT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    logic [1:0]         state_q, state_d;
    logic [A_WIDTH-1:0] pc_q, pc_d;
    logic [A_WIDTH-1:0] epc_q, epc_d;
    logic               fault_q, fault_d;

    logic               redir_vld;
    logic [A_WIDTH-1:0] redir_tgt;
    logic               redir_misalign;

    // EX redirect wins over ID: the ID jump belongs to a younger, squashed instruction.
    always_comb begin
        redir_vld      = ex_branch_taken | id_jump;
        redir_tgt      = ex_branch_taken ? ex_branch_target : id_jump_target;
        redir_misalign = |redir_tgt[1:0];
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        fault_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (trap_req) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = trap_epc;
                end else if (mret) begin
                    pc_d = epc_q;
                end else if (redir_vld) begin
                    if (redir_misalign) begin
                        pc_d    = TRAP_VECTOR;
                        epc_d   = redir_tgt;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (!stall) begin
                    pc_d = pc_q + A_WIDTH'(4);
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            fault_q <= fault_d;
        end
    end

    assign pc_out         = pc_q;
    assign pc_plus4       = pc_q + A_WIDTH'(4);
    assign epc            = epc_q;
    assign misalign_fault = fault_q;
    assign fetch_valid    = (state_q == ST_RUN);
    assign halted         = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed stimulus pushes hand-computed expectations into a queue; a monitor pops and compares.
// A second 8-bit instance exercises PC wrap-around.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, trap_req, mret, ex_branch_taken, id_jump, halt_req, resume;
    logic [31:0] trap_epc, ex_branch_target, id_jump_target;
    logic [31:0] pc_out, pc_plus4, epc;
    logic        fetch_valid, misalign_fault, halted;

    logic        id_jump8;
    logic [7:0]  id_jump_target8;
    logic [7:0]  pc8, pc8_plus4, epc8;
    logic        fv8, mf8, h8;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        sel8;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        fv;
        logic        h;
        logic        f;
        logic [7:0]  pc8;
    } exp_t;

    exp_t  eq[$];
    string nq[$];
    event  chk_ev;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .trap_req(trap_req), .trap_epc(trap_epc),
        .mret(mret), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .id_jump(id_jump), .id_jump_target(id_jump_target), .halt_req(halt_req), .resume(resume),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .epc(epc),
        .misalign_fault(misalign_fault), .halted(halted)
    );

    pc_unit #(.A_WIDTH(8), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h80)) dut8 (
        .clk(clk), .rst(rst), .stall(1'b0), .trap_req(1'b0), .trap_epc(8'h00),
        .mret(1'b0), .ex_branch_taken(1'b0), .ex_branch_target(8'h00),
        .id_jump(id_jump8), .id_jump_target(id_jump_target8), .halt_req(1'b0), .resume(1'b0),
        .pc_out(pc8), .pc_plus4(pc8_plus4), .fetch_valid(fv8), .epc(epc8),
        .misalign_fault(mf8), .halted(h8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: compares every queued expectation at the next sampling point.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk or chk_ev);
            while (eq.size() > 0) begin
                e  = eq.pop_front();
                nm = nq.pop_front();
                if (e.sel8) begin
                    chk({nm, ".pc8"},    {24'h0, pc8},       {24'h0, e.pc8});
                    chk({nm, ".pc8p4"},  {24'h0, pc8_plus4}, {24'h0, e.pc8 + 8'd4});
                    chk({nm, ".fv8"},    {31'h0, fv8},       32'd1);
                    chk({nm, ".state8"}, {29'h0, h8, mf8, |epc8}, 32'd0);
                end else begin
                    chk({nm, ".pc"},    pc_out,                  e.pc);
                    chk({nm, ".pcp4"},  pc_plus4,                e.pc + 32'd4);
                    chk({nm, ".epc"},   epc,                     e.epc);
                    chk({nm, ".fv"},    {31'h0, fetch_valid},    {31'h0, e.fv});
                    chk({nm, ".halt"},  {31'h0, halted},         {31'h0, e.h});
                    chk({nm, ".fault"}, {31'h0, misalign_fault}, {31'h0, e.f});
                end
            end
        end
    end

    task automatic clear_inputs();
        stall = 0; trap_req = 0; mret = 0; ex_branch_taken = 0; id_jump = 0;
        halt_req = 0; resume = 0; trap_epc = '0; ex_branch_target = '0; id_jump_target = '0;
        id_jump8 = 0; id_jump_target8 = '0;
    endtask

    task automatic push(input string nm, input exp_t e);
        eq.push_back(e);
        nq.push_back(nm);
    endtask

    // Apply the currently driven inputs for one edge, then queue what must follow it.
    task automatic step(input string nm, input logic [31:0] pc, input logic [31:0] e_epc,
                        input logic fv, input logic h, input logic f);
        @(posedge clk);
        #1;
        push(nm, '{sel8: 1'b0, pc: pc, epc: e_epc, fv: fv, h: h, f: f, pc8: 8'h00});
        clear_inputs();
    endtask

    task automatic step8(input string nm, input logic [7:0] p8);
        @(posedge clk);
        #1;
        push(nm, '{sel8: 1'b1, pc: 32'h0, epc: 32'h0, fv: 1'b0, h: 1'b0, f: 1'b0, pc8: p8});
        clear_inputs();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        #2;
        push("rst", '{sel8: 1'b0, pc: 32'h0, epc: 32'h0, fv: 1'b0, h: 1'b0, f: 1'b0, pc8: 8'h00});
        -> chk_ev;
        #10 rst = 0;

        step("boot0", 32'h0, 32'h0, 1, 0, 0);
        step("inc4",  32'h4, 32'h0, 1, 0, 0);
        step("inc8",  32'h8, 32'h0, 1, 0, 0);
        for (int i = 3; i <= 8; i++) step("run", 32'(i * 4), 32'h0, 1, 0, 0);

        stall = 1; step("stall1", 32'h20, 32'h0, 1, 0, 0);
        stall = 1; step("stall2", 32'h20, 32'h0, 1, 0, 0);
        step("unstall", 32'h24, 32'h0, 1, 0, 0);

        ex_branch_taken = 1; ex_branch_target = 32'h80;
        id_jump = 1; id_jump_target = 32'h40; stall = 1;
        step("ex_over_id", 32'h80, 32'h0, 1, 0, 0);

        id_jump = 1; id_jump_target = 32'h10;
        step("jump10", 32'h10, 32'h0, 1, 0, 0);
        id_jump = 1; id_jump_target = 32'h42;
        step("id_misalign", 32'h100, 32'h42, 1, 0, 1);
        mret = 1;
        step("mret42", 32'h42, 32'h42, 1, 0, 0);
        step("inc46", 32'h46, 32'h42, 1, 0, 0);

        trap_req = 1; trap_epc = 32'h30; mret = 1;
        step("trap_over_mret", 32'h100, 32'h30, 1, 0, 0);
        mret = 1;
        step("mret30", 32'h30, 32'h30, 1, 0, 0);
        step("inc34", 32'h34, 32'h30, 1, 0, 0);

        ex_branch_taken = 1; ex_branch_target = 32'h83;
        id_jump = 1; id_jump_target = 32'h40;
        step("ex_misalign", 32'h100, 32'h83, 1, 0, 1);
        stall = 1;
        step("fault_clr", 32'h100, 32'h83, 1, 0, 0);
        id_jump = 1; id_jump_target = 32'h50; stall = 1;
        step("jump_over_stall", 32'h50, 32'h83, 1, 0, 0);

        halt_req = 1;
        step("halt", 32'h50, 32'h83, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            ex_branch_taken = 1; ex_branch_target = 32'h80;
            trap_req = (i == 1); trap_epc = 32'h10;
            step("halted_ignore", 32'h50, 32'h83, 0, 1, 0);
        end
        resume = 1;
        step("resume", 32'h50, 32'h83, 1, 0, 0);
        step("inc54", 32'h54, 32'h83, 1, 0, 0);

        halt_req = 1; id_jump = 1; id_jump_target = 32'h60;
        step("halt_lost", 32'h60, 32'h83, 1, 0, 0);
        halt_req = 1;
        step("halt2", 32'h60, 32'h83, 0, 1, 0);

        // Reset pulse while the clock is low and no edge occurs: must act asynchronously.
        @(negedge clk);
        #1 rst = 1;
        #1;
        push("async_rst", '{sel8: 1'b0, pc: 32'h0, epc: 32'h0, fv: 1'b0, h: 1'b0, f: 1'b0, pc8: 8'h00});
        -> chk_ev;
        #1 rst = 0;
        step("reboot", 32'h0, 32'h0, 1, 0, 0);

        id_jump8 = 1; id_jump_target8 = 8'hFC;
        step8("w8_fc", 8'hFC);
        step8("w8_wrap", 8'h00);

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 32'(eq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
